// File: rtl/vga_pkg.sv
// Shared constants and arbiter state encoding for the VGA frame-buffer path.
package vga_pkg;

  localparam int FB_W   = 128;
  localparam int FB_H   = 96;
  localparam int ADDR_W = $clog2(FB_W * FB_H);
  localparam int DATA_W = 3;
  localparam int CNT_W  = 7;
  localparam logic [CNT_W-1:0] STALL_LIMIT = 7'd64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN      = 2'd1,
    DRAIN     = 2'd2,
    SCAN_PEND = 2'd3
  } arb_state_t;

endpackage

// File: rtl/vram_write_buffer.sv
// One-entry posted-write buffer with scan bypass compare and a saturating stall counter.
module vram_write_buffer #(
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int DATA_W = vga_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_now,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              wr_ready,
  output logic              wb_full,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data,
  output logic              wr_stall
);
  import vga_pkg::*;

  logic              wb_full_q, wb_full_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              byp_hit_q, byp_hit_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic              accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign wr_ready = !wb_full_q || drain_now;
  assign accept   = wr_req && wr_ready;

  always_comb begin
    wb_full_d  = wb_full_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    cnt_d      = cnt_q;
    // A write accepted on a drain cycle refills the entry the RAM is taking.
    if (accept) begin
      wb_full_d = 1'b1;
      wb_addr_d = wr_addr;
      wb_data_d = wr_data;
    end else if (drain_now) begin
      wb_full_d = 1'b0;
    end
    if (drain_now)      cnt_d = '0;
    else if (wb_full_q) cnt_d = sat_inc(cnt_q);
    byp_hit_d  = scan_req && wb_full_q && (scan_addr == wb_addr_q);
    byp_data_d = wb_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_full_q <= 1'b0;
      cnt_q     <= '0;
      byp_hit_q <= 1'b0;
    end else begin
      wb_full_q <= wb_full_d;
      cnt_q     <= cnt_d;
      byp_hit_q <= byp_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    wb_addr_q  <= wb_addr_d;
    wb_data_q  <= wb_data_d;
    byp_data_q <= byp_data_d;
  end

  assign wb_full  = wb_full_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign byp_hit  = byp_hit_q;
  assign byp_data = byp_data_q;
  assign wr_stall = (cnt_q >= STALL_LIMIT);

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads win every cycle, posted writes drain into idle cycles.
module vga_vram_arbiter #(
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int DATA_W = vga_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              resetbutton,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_stall
);
  import vga_pkg::*;

  arb_state_t        state_q, state_d;
  logic              wb_full, drain_now, byp_hit;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data, byp_data;

  // Decision and memory drive are both combinational so a read goes out the cycle it is requested.
  always_comb begin
    state_d   = IDLE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (scan_req)     state_d = wb_full ? SCAN_PEND : SCAN;
    else if (wb_full) state_d = DRAIN;
    case (state_d)
      SCAN, SCAN_PEND: begin
        mem_en   = 1'b1;
        mem_addr = scan_addr;
      end
      DRAIN: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_addr;
        mem_wdata = wb_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetbutton) begin
    if (!resetbutton) state_q <= IDLE;
    else              state_q <= state_d;
  end

  assign drain_now = (state_d == DRAIN);

  vram_write_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wbuf (
    .clk       (clk),
    .rst_n     (resetbutton),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .drain_now (drain_now),
    .scan_req  (scan_req),
    .scan_addr (scan_addr),
    .wr_ready  (wr_ready),
    .wb_full   (wb_full),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data),
    .wr_stall  (wr_stall)
  );

  // Registered read phase: the RAM answers one cycle after the read was issued.
  assign scan_valid = (state_q == SCAN) || (state_q == SCAN_PEND);
  assign scan_data  = !scan_valid ? '0 : (byp_hit ? byp_data : mem_rdata);

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: vector table, scoreboard of scan pixels, stall and reset sequences.
module tb_vga_vram_arbiter;
  localparam int AW = 14;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          resetbutton;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_valid;
  logic [DW-1:0] scan_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          wr_stall;

  vga_vram_arbiter dut (
    .clk        (clk),
    .resetbutton(resetbutton),
    .scan_req   (scan_req),
    .scan_addr  (scan_addr),
    .scan_valid (scan_valid),
    .scan_data  (scan_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .wr_stall   (wr_stall)
  );

  always #10 clk = ~clk;

  logic [DW-1:0] ram  [0:(1<<AW)-1];
  logic [DW-1:0] gold [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic          sreq;
    logic [AW-1:0] saddr;
    logic          wreq;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          e_rdy;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] sb[$];
  logic          prev_scan = 1'b0;
  int            checks = 0;
  int            errors = 0;

  function automatic vec_t v(input logic sreq, input logic [AW-1:0] saddr,
                             input logic wreq, input logic [AW-1:0] waddr,
                             input logic [DW-1:0] wdata, input logic e_rdy,
                             input logic e_en, input logic e_we,
                             input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wdata);
    vec_t r;
    r.sreq = sreq; r.saddr = saddr; r.wreq = wreq; r.waddr = waddr; r.wdata = wdata;
    r.e_rdy = e_rdy; r.e_en = e_en; r.e_we = e_we; r.e_addr = e_addr; r.e_wdata = e_wdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t r, input logic e_stall, input string tag);
    logic [DW-1:0] e_pix;
    @(negedge clk);
    if (prev_scan) begin
      chk({tag, " scan_valid"}, 32'(scan_valid), 32'd1);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s scoreboard empty", tag);
      end else begin
        e_pix = sb.pop_front();
        chk({tag, " scan_data"}, 32'(scan_data), 32'(e_pix));
      end
    end else begin
      chk({tag, " scan_valid"}, 32'(scan_valid), 32'd0);
    end
    chk({tag, " wr_stall"}, 32'(wr_stall), 32'(e_stall));
    scan_req  = r.sreq;
    scan_addr = r.saddr;
    wr_req    = r.wreq;
    wr_addr   = r.waddr;
    wr_data   = r.wdata;
    #1;
    chk({tag, " wr_ready"}, 32'(wr_ready), 32'(r.e_rdy));
    chk({tag, " mem_en"},   32'(mem_en),   32'(r.e_en));
    chk({tag, " mem_we"},   32'(mem_we),   32'(r.e_we));
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(r.e_addr));
    if (r.e_we) chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(r.e_wdata));
    if (r.sreq) sb.push_back(gold[r.saddr]);
    if (r.wreq && r.e_rdy) gold[r.waddr] = r.wdata;
    prev_scan = r.sreq;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " scan_valid"}, 32'(scan_valid), 32'd0);
    chk({tag, " scan_data"},  32'(scan_data),  32'd0);
    chk({tag, " wr_ready"},   32'(wr_ready),   32'd1);
    chk({tag, " mem_en"},     32'(mem_en),     32'd0);
    chk({tag, " mem_we"},     32'(mem_we),     32'd0);
    chk({tag, " mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, " mem_wdata"},  32'(mem_wdata),  32'd0);
    chk({tag, " wr_stall"},   32'(wr_stall),   32'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      a = AW'(i);
      ram[i]  = a[2:0];
      gold[i] = a[2:0];
    end
    mem_rdata   = '0;
    resetbutton = 1'b0;
    scan_req = 1'b0; scan_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;

    // Idle, scan stream, idle write, bypass and back-to-back write vectors.
    for (int i = 0; i < 8; i++) tbl.push_back(v(1, AW'(i), 0, 0, 0, 1, 1, 0, AW'(i), 0));
    tbl.push_back(v(0, 0,      0, 0,      0, 1, 0, 0, 0,      0));
    tbl.push_back(v(0, 0,      1, 'h100, 5, 1, 0, 0, 0,      0));
    tbl.push_back(v(0, 0,      0, 0,      0, 1, 1, 1, 'h100, 5));
    tbl.push_back(v(1, 'h100, 0, 0,      0, 1, 1, 0, 'h100, 0));
    tbl.push_back(v(1, 'h005, 1, 'h200, 3, 1, 1, 0, 'h005, 0));
    tbl.push_back(v(1, 'h200, 0, 0,      0, 0, 1, 0, 'h200, 0));
    tbl.push_back(v(0, 0,      0, 0,      0, 1, 1, 1, 'h200, 3));
    tbl.push_back(v(1, 'h200, 0, 0,      0, 1, 1, 0, 'h200, 0));
    tbl.push_back(v(0, 0,      1, 'h300, 6, 1, 0, 0, 0,      0));
    tbl.push_back(v(0, 0,      1, 'h301, 7, 1, 1, 1, 'h300, 6));
    tbl.push_back(v(0, 0,      0, 0,      0, 1, 1, 1, 'h301, 7));
    tbl.push_back(v(1, 'h300, 0, 0,      0, 1, 1, 0, 'h300, 0));
    tbl.push_back(v(1, 'h301, 0, 0,      0, 1, 1, 0, 'h301, 0));
    tbl.push_back(v(0, 0,      0, 0,      0, 1, 0, 0, 0,      0));

    #100;
    chk_reset_outputs("reset_hold");
    @(negedge clk);
    resetbutton = 1'b1;
    #1;
    chk_reset_outputs("reset_release");

    foreach (tbl[i]) step(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Contention: continuous scan, one write buffered, the next held off until scan stops.
    for (int c = 1; c <= 20; c++) begin
      if (c == 1)      step(v(1, AW'('h10 + c), 0, 0, 0, 1, 1, 0, AW'('h10 + c), 0), 1'b0, "cont");
      else if (c == 2) step(v(1, AW'('h10 + c), 1, 'h400, 2, 1, 1, 0, AW'('h10 + c), 0), 1'b0, "cont");
      else             step(v(1, AW'('h10 + c), 1, 'h401, 4, 0, 1, 0, AW'('h10 + c), 0), 1'b0, "cont");
    end
    step(v(0, 0,      1, 'h401, 4, 1, 1, 1, 'h400, 2), 1'b0, "cont_drain");
    step(v(0, 0,      0, 0,      0, 1, 1, 1, 'h401, 4), 1'b0, "cont_drain2");
    step(v(1, 'h400, 0, 0,      0, 1, 1, 0, 'h400, 0), 1'b0, "cont_rd0");
    step(v(1, 'h401, 0, 0,      0, 1, 1, 0, 'h401, 0), 1'b0, "cont_rd1");
    step(v(0, 0,      0, 0,      0, 1, 0, 0, 0,      0), 1'b0, "cont_end");

    // Long stall: stall flag from 64 full cycles onward, and it must hold past 128.
    step(v(1, 'h600, 1, 'h500, 1, 1, 1, 0, 'h600, 0), 1'b0, "stall0");
    for (int k = 1; k <= 140; k++)
      step(v(1, AW'('h600 + k), 1, 'h501, 2, 0, 1, 0, AW'('h600 + k), 0), (k >= 65), $sformatf("stall%0d", k));

    // Mid-operation reset discards the buffered write.
    @(negedge clk);
    resetbutton = 1'b0;
    scan_req = 1'b0; wr_req = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb.delete();
    prev_scan = 1'b0;
    gold['h500] = 3'(12'h500 & 12'h7);
    repeat (2) @(negedge clk);
    resetbutton = 1'b1;
    for (int k = 0; k < 3; k++) step(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0, "post_reset");
    step(v(1, 'h500, 0, 0, 0, 1, 1, 0, 'h500, 0), 1'b0, "post_rd");
    step(v(0, 0,      0, 0, 0, 1, 0, 0, 0,      0), 1'b0, "post_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
